seq_smul_unit: RTL and testbench
================================

// Module: seq_smul_unit
// PURPOSE
//  Iterative signed multiplier. It sits downstream of ALU control, in parallel with the ALU.
//  It executes the signed-multiply op (ALUCtrl code 13, A_SMUL), which is too slow for the
//  single-cycle ALU path: radix-2 shift-add over magnitudes, then a sign fix-up.
//  busy_o is used by the hazard/stall logic to freeze the pipeline. done_o marks a valid result.
// PARAMETERS
//  WIDTH      32   operand and result width in bits (>=4)
//  SMUL_CODE  13   ALUCtrl_i value that requests a multiply
// PORTS
//  clk_i      in   1      clock; all state changes on the rising edge
//  rst_i      in   1      synchronous reset, active-high
//  ALUCtrl_i  in   4      ALU control code from ALU control
//  start_i    in   1      operands/op valid this cycle
//  src1_i     in   WIDTH  multiplicand, two's complement
//  src2_i     in   WIDTH  multiplier, two's complement
//  result_o   out  WIDTH  low WIDTH bits of the signed product
//  busy_o     out  1      multiply in progress; upstream must hold the pipeline
//  done_o     out  1      one-cycle pulse: result_o is newly valid
//  hi_o       out  WIDTH  high WIDTH bits of the product (only with SMUL_HI_EN)
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): state=IDLE; result_o=0, busy_o=0, done_o=0, hi_o=0.
//    Reset wins over any concurrent start_i.
//  - FSM states: IDLE, CALC, FIX, DONE.
//  - IDLE->CALC when start_i=1 && ALUCtrl_i==SMUL_CODE.
//    * Latch |src1_i|, |src2_i| and neg = src1_i[W-1]^src2_i[W-1].
//    * Clear the accumulator and set the bit counter to 0.
//  - Otherwise IDLE holds. Any other ALUCtrl_i value, or start_i=0, is ignored.
//  - CALC: one multiplier bit per cycle, LSB first.
//    * If mplr[0]=1, acc += mcand.
//    * Then mcand <<= 1, mplr >>= 1, cnt++.
//    * When cnt==WIDTH-1 at an edge, go to FIX. CALC lasts exactly WIDTH cycles.
//  - FIX: result_o <= neg ? -acc : acc (two's complement, truncated to the kept width). Go to DONE.
//  - DONE: done_o=1 for exactly one cycle. Go to IDLE at the next edge.
//  - busy_o=1 in CALC and FIX only, and is 0 in IDLE and DONE.
//  - Latency: done_o is high in the cycle after WIDTH+1 edges counted from the accepting edge
//    (33 edges for WIDTH=32). Throughput: one op per WIDTH+3 cycles.
//  - start_i in CALC, FIX or DONE is ignored: no queueing, and no abort of the current op.
//  - result_o holds its last value until the next FIX. It is not cleared by new starts.
//  - Operands are sampled only at the accepting edge. Input changes during busy_o have no effect.
//  - Magnitude of -2^(W-1) is 2^(W-1) in W unsigned bits. No overflow flag is produced;
//    the low bits wrap modulo 2^WIDTH.
//  - Reset during CALC or FIX aborts the op: IDLE, outputs zeroed, no done_o pulse.
// CONFIGURATION
//  SMUL_HI_EN defined:
//    * Accumulator is 2*WIDTH bits and the hi_o port exists.
//    * In FIX, {hi_o,result_o} <= signed 2*WIDTH product; hi_o holds like result_o.
//  SMUL_HI_EN undefined:
//    * hi_o port absent.
//    * Accumulator and mcand are WIDTH bits; only the low product is computed.
//    * Timing and result_o are identical to the defined case.
// TESTING (WIDTH=32)
//  1. Reset held 2 cycles, then released.
//     -> result_o=0, busy_o=0, done_o=0, and they stay so while start_i=0.
//  2. start_i=1, ALUCtrl_i=13, src1=7, src2=-3.
//     -> busy_o=1 for 33 cycles, then done_o pulses once, result_o=0xFFFFFFEB (-21);
//        with SMUL_HI_EN, hi_o=0xFFFFFFFF.
//  3. src1=0x80000000, src2=0xFFFFFFFF.
//     -> result_o=0x80000000; with SMUL_HI_EN, hi_o=0x00000000.
//  4. start_i=1 with ALUCtrl_i=4 (ADDU), src1=5, src2=6.
//     -> no busy_o, no done_o, result_o unchanged.
//  5. Start 12*12. Re-pulse start_i with 3*3 at cycle 10 of CALC.
//     -> a single done_o, result_o=144, and the second request is dropped.
//  6. Start -5*9, assert rst_i for 1 cycle at cycle 20 of CALC.
//     -> IDLE next cycle, outputs 0, no done_o; a following 2*2 yields 4 after 33 edges.

Source files
------------

// File: rtl/seq_smul_unit.sv
// seq_smul_unit: iterative radix-2 signed multiplier (shift-add on magnitudes, then sign fix-up).
// Define SMUL_HI_EN to keep a 2*WIDTH accumulator and drive the high product half on hi_o.
module seq_smul_unit #(
   parameter int         WIDTH     = 32,
   parameter logic [3:0] SMUL_CODE = 4'd13
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o,
   output logic             done_o,
`ifdef SMUL_HI_EN
   output logic [WIDTH-1:0] hi_o,
`endif
   output logic [1:0]       state_o
);

`ifdef SMUL_HI_EN
   localparam int AW = 2 * WIDTH;
`else
   localparam int AW = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     mcand;
   logic [WIDTH-1:0]  mplr;
   logic              neg;
   logic [CW-1:0]     cnt;

   logic [WIDTH-1:0]  mag1;
   logic [WIDTH-1:0]  mag2;
   logic [AW-1:0]     acc_fix;

   assign state_o = state;

   // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
   always_comb begin
      mag1    = src1_i[WIDTH-1] ? -src1_i : src1_i;
      mag2    = src2_i[WIDTH-1] ? -src2_i : src2_i;
      acc_fix = neg ? -acc : acc;
   end

   // Handshake: start_i is taken only in IDLE with ALUCtrl_i==SMUL_CODE; while busy_o is
   // high every start_i is dropped; done_o pulses one cycle when result_o is freshly valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplr     <= '0;
         neg      <= 1'b0;
         cnt      <= '0;
         result_o <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
`ifdef SMUL_HI_EN
         hi_o     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done_o <= 1'b0;
               if (start_i && (ALUCtrl_i == SMUL_CODE)) begin
                  mcand  <= AW'(mag1);
                  mplr   <= mag2;
                  neg    <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
                  acc    <= '0;
                  cnt    <= '0;
                  busy_o <= 1'b1;
                  state  <= S_CALC;
               end
            end
            S_CALC: begin
               if (mplr[0]) acc <= acc + mcand;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               result_o <= acc_fix[WIDTH-1:0];
`ifdef SMUL_HI_EN
               hi_o     <= acc_fix[AW-1:WIDTH];
`endif
               busy_o   <= 1'b0;
               done_o   <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               done_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_smul_unit.sv
// Directed bench for seq_smul_unit (WIDTH=32): vector table plus mid-op restart and reset sequences.
module tb_seq_smul_unit;
   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [3:0]    ALUCtrl_i = 4'd0;
   logic          start_i = 1'b0;
   logic [W-1:0]  src1_i = '0;
   logic [W-1:0]  src2_i = '0;
   logic [W-1:0]  result_o;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    state_o;
`ifdef SMUL_HI_EN
   logic [W-1:0]  hi_o;
`endif

   seq_smul_unit #(.WIDTH(W), .SMUL_CODE(4'd13)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ALUCtrl_i (ALUCtrl_i),
      .start_i   (start_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .result_o  (result_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
`ifdef SMUL_HI_EN
      .hi_o      (hi_o),
`endif
      .state_o   (state_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   code;
      logic         is_mul;
      logic [W-1:0] exp_lo;
      logic [W-1:0] exp_hi;
   } vec_t;

   vec_t          vecs[12];
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_hi_q[$];
   logic [W-1:0]  last_lo;
   logic [W-1:0]  last_hi;
   int            checks = 0;
   int            errors = 0;
   int            busy_cnt;
   int            done_cnt;
   int            done_at;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare a done pulse against the scoreboard head.
   task automatic score_done();
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_done: got done_o=1 expected no pulse");
      end else begin
         errors--;
         checks--;
         e = exp_q.pop_front();
         check("done_result", {32'd0, result_o}, {32'd0, e});
         check("busy_during_done", {63'd0, busy_o}, 64'd0);
         last_lo = e;
`ifdef SMUL_HI_EN
         e = exp_hi_q.pop_front();
         check("done_hi", {32'd0, hi_o}, {32'd0, e});
         last_hi = e;
`endif
         errors++;
      end
   endtask

   // Observe n negedges starting right after the accepting edge.
   task automatic watch(input int n, input int inj_at, input int inj_kind);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int i = 0; i < n; i++) begin
         if (inj_kind == 1 && i == inj_at) begin
            start_i = 1'b1; ALUCtrl_i = 4'd13; src1_i = 32'd3; src2_i = 32'd3;
         end else if (inj_kind == 1 && i == inj_at + 1) begin
            start_i = 1'b0;
         end
         if (inj_kind == 2 && i == inj_at) rst_i = 1'b1;
         if (inj_kind == 2 && i == inj_at + 1) begin
            rst_i = 1'b0;
            check("rst_abort_busy", {63'd0, busy_o}, 64'd0);
            check("rst_abort_result", {32'd0, result_o}, 64'd0);
            check("rst_abort_state", {62'd0, state_o}, 64'd0);
            last_lo = '0;
            last_hi = '0;
            exp_q.delete();
            exp_hi_q.delete();
         end
         if (busy_o) busy_cnt++;
         if (done_o) begin
            done_cnt++;
            done_at = i;
            score_done();
         end
         @(negedge clk_i);
      end
   endtask

   // driver: one-cycle start pulse, then scramble inputs while busy
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code);
      start_i = 1'b1; ALUCtrl_i = code; src1_i = a; src2_i = b;
      @(negedge clk_i);
      start_i = 1'b0;
      src1_i = $urandom;
      src2_i = $urandom;
      ALUCtrl_i = 4'($urandom_range(0, 15));
   endtask

   task automatic run_vec(input vec_t v);
      if (v.is_mul) begin
         exp_q.push_back(v.exp_lo);
         exp_hi_q.push_back(v.exp_hi);
      end
      issue(v.a, v.b, v.code);
      watch(40, 0, 0);
      check("busy_cycles", 64'(busy_cnt), v.is_mul ? 64'd33 : 64'd0);
      check("done_pulses", 64'(done_cnt), v.is_mul ? 64'd1 : 64'd0);
      if (v.is_mul) check("done_latency", 64'(done_at), 64'd33);
      check("result_hold", {32'd0, result_o}, {32'd0, last_lo});
`ifdef SMUL_HI_EN
      check("hi_hold", {32'd0, hi_o}, {32'd0, last_hi});
`endif
   endtask

   initial begin
      vecs[0]  = '{32'd7,        32'hFFFFFFFD, 4'd13, 1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF};
      vecs[1]  = '{32'h80000000, 32'hFFFFFFFF, 4'd13, 1'b1, 32'h80000000, 32'h00000000};
      vecs[2]  = '{32'd5,        32'd6,        4'd4,  1'b0, 32'h0,        32'h0};
      vecs[3]  = '{32'h00012345, 32'h00000010, 4'd13, 1'b1, 32'h00123450, 32'h00000000};
      vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd13, 1'b1, 32'h00000001, 32'h00000000};
      vecs[5]  = '{32'h80000000, 32'h80000000, 4'd13, 1'b1, 32'h00000000, 32'h40000000};
      vecs[6]  = '{32'h7FFFFFFF, 32'd2,        4'd13, 1'b1, 32'hFFFFFFFE, 32'h00000000};
      vecs[7]  = '{32'd0,        32'hFFFFFFF9, 4'd13, 1'b1, 32'h00000000, 32'h00000000};
      vecs[8]  = '{32'd3,        32'd3,        4'd12, 1'b0, 32'h0,        32'h0};
      vecs[9]  = '{32'hFFFFFF9C, 32'd1000,     4'd13, 1'b1, 32'hFFFE7960, 32'hFFFFFFFF};
      vecs[10] = '{32'h00010000, 32'h00010000, 4'd13, 1'b1, 32'h00000000, 32'h00000001};
      vecs[11] = '{32'd3,        32'd5,        4'd13, 1'b0, 32'h0,        32'h0};
      vecs[11].code = 4'd14;
      last_lo = '0;
      last_hi = '0;

      // reset held two cycles with a competing multiply request
      start_i = 1'b1; ALUCtrl_i = 4'd13; src1_i = 32'd9; src2_i = 32'd9;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0; start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("reset_result", {32'd0, result_o}, 64'd0);
         check("reset_busy", {63'd0, busy_o}, 64'd0);
         check("reset_done", {63'd0, done_o}, 64'd0);
         check("reset_state", {62'd0, state_o}, 64'd0);
         @(negedge clk_i);
      end

      for (int k = 0; k < 12; k++) run_vec(vecs[k]);

      // second request during CALC is dropped
      exp_q.push_back(32'd144);
      exp_hi_q.push_back(32'd0);
      issue(32'd12, 32'd12, 4'd13);
      watch(50, 10, 1);
      check("restart_done_pulses", 64'(done_cnt), 64'd1);
      check("restart_latency", 64'(done_at), 64'd33);
      check("restart_result", {32'd0, result_o}, 64'd144);

      // reset mid-CALC aborts with no done pulse
      exp_q.push_back(32'hFFFFFFD3);
      exp_hi_q.push_back(32'hFFFFFFFF);
      issue(32'hFFFFFFFB, 32'd9, 4'd13);
      watch(40, 20, 2);
      check("abort_done_pulses", 64'(done_cnt), 64'd0);
      check("abort_result", {32'd0, result_o}, 64'd0);

      exp_q.push_back(32'd4);
      exp_hi_q.push_back(32'd0);
      issue(32'd2, 32'd2, 4'd13);
      watch(40, 0, 0);
      check("post_abort_done_pulses", 64'(done_cnt), 64'd1);
      check("post_abort_latency", 64'(done_at), 64'd33);
      check("post_abort_result", {32'd0, result_o}, 64'd4);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
